// File: rtl/input_sync_debounce.sv
// Conditions a raw asynchronous input: a flop-chain synchroniser feeds a
// consecutive-cycle debounce counter that drives a clean level and edge pulses.
module input_sync_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0,
    localparam int  CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    input  logic en_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   level_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   busy_r;

    logic                   s_s;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   level_nxt_s;
    logic                   rise_nxt_s;
    logic                   fall_nxt_s;

    assign s_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain: plain shift register, no logic between stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_i};
        end
    end

    // Debounce next-state: any disagreement lapse or disable restarts the count.
    always_comb begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        level_nxt_s = level_r;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        if (en_i && (s_s != level_r)) begin
            if (cnt_r == CNT_LAST) begin
                cnt_nxt_s   = {CNT_W{1'b0}};
                level_nxt_s = s_s;
                rise_nxt_s  = s_s;
                fall_nxt_s  = ~s_s;
            end else begin
                cnt_nxt_s   = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= RESET_VAL;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            rise_r  <= rise_nxt_s;
            fall_r  <= fall_nxt_s;
            busy_r  <= (cnt_nxt_s != {CNT_W{1'b0}});
        end
    end

    assign level_o = level_r;
    assign rise_o  = rise_r;
    assign fall_o  = fall_r;
    assign busy_o  = busy_r;

endmodule

// File: tb/tb_input_sync_debounce.sv
// Directed bench for input_sync_debounce with default parameters; expected
// values are hand-computed edge by edge from the latency rules.
module tb_input_sync_debounce;

    logic clk;
    logic reset_n;
    logic async_i;
    logic en_i;
    logic level_o;
    logic rise_o;
    logic fall_o;
    logic busy_o;

    int n_cmp;
    int n_err;

    input_sync_debounce dut (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (async_i),
        .en_i    (en_i),
        .level_o (level_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vector order: {level, rise, fall, busy}
    task automatic test_reset();
        logic [3:0] obs;
        reset_n = 1'b0;
        async_i = 1'b1;
        en_i    = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            obs = {level_o, rise_o, fall_o, busy_o};
            n_cmp++;
            if (obs !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_hold e%0d got %b want %b", e, obs, 4'b0000);
            end
        end
        async_i = 1'b0;
        reset_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            obs = {level_o, rise_o, fall_o, busy_o};
            n_cmp++;
            if (obs !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_release e%0d got %b want %b", e, obs, 4'b0000);
            end
        end
    endtask

    // Three-cycle pulse: count reaches terminal just as s returns to level.
    task automatic test_glitch();
        logic [3:0] obs;
        logic [3:0] exp;
        async_i = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3) async_i = 1'b0;
            exp = {1'b0, 1'b0, 1'b0, (e >= 3 && e <= 5)};
            obs = {level_o, rise_o, fall_o, busy_o};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL glitch e%0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_clean_rise();
        logic [3:0] obs;
        logic [3:0] exp;
        async_i = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = {(e >= 6), (e == 6), 1'b0, (e >= 3 && e <= 5)};
            obs = {level_o, rise_o, fall_o, busy_o};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL clean_rise e%0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_clean_fall();
        logic [3:0] obs;
        logic [3:0] exp;
        async_i = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = {(e < 6), 1'b0, (e == 6), (e >= 3 && e <= 5)};
            obs = {level_o, rise_o, fall_o, busy_o};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL clean_fall e%0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs;
        async_i = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        obs = {level_o, rise_o, fall_o, busy_o};
        n_cmp++;
        if (obs !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_count_busy got %b want %b", obs, 4'b0001);
        end
        #2;
        reset_n = 1'b0;
        #1;
        obs = {level_o, rise_o, fall_o, busy_o};
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset_now got %b want %b", obs, 4'b0000);
        end
        async_i = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            obs = {level_o, rise_o, fall_o, busy_o};
            n_cmp++;
            if (obs !== 4'b0000) begin
                n_err++;
                $display("FAIL after_mid_reset e%0d got %b want %b", e, obs, 4'b0000);
            end
        end
    endtask

    task automatic test_enable();
        logic [3:0] obs;
        logic [3:0] exp;
        en_i    = 1'b0;
        async_i = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            obs = {level_o, rise_o, fall_o, busy_o};
            n_cmp++;
            if (obs !== 4'b0000) begin
                n_err++;
                $display("FAIL en_low e%0d got %b want %b", e, obs, 4'b0000);
            end
        end
        en_i = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp = {(e >= 4), (e == 4), 1'b0, (e >= 1 && e <= 3)};
            obs = {level_o, rise_o, fall_o, busy_o};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL en_high e%0d got %b want %b", e, obs, exp);
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        async_i = 1'b1;
        en_i    = 1'b1;
        test_reset();
        test_glitch();
        test_clean_rise();
        test_clean_fall();
        test_reset_mid();
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
